uart_rx: RTL and testbench

- Serial UART receiver; the receive-side counterpart of the UART TX path.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Oversamples the line at a runtime prescale, majority-votes each bit, checks parity (even/odd) and stop bit, and presents the byte with a one-cycle valid pulse.
- Sits between the RX pin and the register file / system controller.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled, majority-voted, with optional parity and a stop check.
// Presents each good byte with a one-cycle data_valid pulse.
module uart_rx #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  Par_en,
    input  logic                  Par_type,
    output logic [DATA_W-1:0]     P_Data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q;
    logic                  sync0_q;
    logic                  rx_s_q;
    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q;
    logic [1:0]            smp_q;
    logic [DATA_W-1:0]     shift_q;
    logic [DATA_W-1:0]     pdata_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_bad_q;
    logic                  dv_q;
    logic                  pe_q;
    logic                  se_q;

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] smp0_pt;
    logic [PRESCALE_W-1:0] smp1_pt;
    logic [PRESCALE_W-1:0] dec_pt;
    logic [PRESCALE_W-1:0] last_pt;
    logic                  at_dec;
    logic                  at_last;
    logic                  bit_v;
    logic                  exp_par;

    always_comb begin
        half    = prescale >> 1;
        smp0_pt = half - PRESCALE_W'(1);
        smp1_pt = half;
        dec_pt  = half + PRESCALE_W'(1);
        last_pt = prescale - PRESCALE_W'(1);
        at_dec  = (edge_cnt_q == dec_pt);
        at_last = (edge_cnt_q == last_pt);
        edge_cnt_d = at_last ? '0 : edge_cnt_q + PRESCALE_W'(1);
        // third sample is the live synchronized line at the decision point
        bit_v   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q)
                | (smp_q[1] & rx_s_q);
        exp_par = (^shift_q) ^ par_type_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync0_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            pdata_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_bad_q  <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            sync0_q <= rx_in;
            rx_s_q  <= sync0_q;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
            if (edge_cnt_q == smp0_pt) smp_q[0] <= rx_s_q;
            if (edge_cnt_q == smp1_pt) smp_q[1] <= rx_s_q;
            unique case (state_q)
                IDLE: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    par_bad_q  <= 1'b0;
                    if (!rx_s_q) begin
                        state_q    <= START;
                        par_en_q   <= Par_en;
                        par_type_q <= Par_type;
                    end
                end
                START: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_dec && bit_v) begin
                        state_q <= IDLE;
                    end else if (at_last) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_dec) shift_q <= {bit_v, shift_q[DATA_W-1:1]};
                    if (at_last) begin
                        if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    edge_cnt_q <= edge_cnt_d;
                    if (at_dec && (bit_v != exp_par)) par_bad_q <= 1'b1;
                    if (at_last) state_q <= STOP;
                end
                STOP: begin
                    edge_cnt_q <= edge_cnt_d;
                    // leave mid-bit so a back-to-back start edge is not missed
                    if (at_dec) begin
                        state_q <= IDLE;
                        if (!bit_v) begin
                            se_q <= 1'b1;
                            pe_q <= par_bad_q;
                        end else if (par_bad_q) begin
                            pe_q <= 1'b1;
                        end else begin
                            dv_q    <= 1'b1;
                            pdata_q <= shift_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign P_Data     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level outcome model plus literal anchors.
// Pulse times are counted from the first clock edge that samples rx_in low.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       Par_en = 1'b0;
    logic       Par_type = 1'b0;
    logic [7:0] P_Data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .prescale(prescale),
        .Par_en(Par_en),
        .Par_type(Par_type),
        .P_Data(P_Data),
        .data_valid(data_valid),
        .par_err(par_err),
        .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         at;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] m_pdata = 8'h00;
    int         errors = 0;
    int         checks = 0;
    int         dv_seen = 0;
    int         pe_seen = 0;
    int         se_seen = 0;
    int         last_dv_cyc = 0;
    logic [7:0] dv_log[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit edv, epe, ese;
        edv = 1'b0;
        epe = 1'b0;
        ese = 1'b0;
        if (!rst) begin
            evq.delete();
            m_pdata = 8'h00;
        end else begin
            while (evq.size() > 0 && evq[0].at < cyc) begin
                chk("missed_event_cycle", evq[0].at, cyc);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].at == cyc) begin
                edv = evq[0].dv;
                epe = evq[0].pe;
                ese = evq[0].se;
                if (edv) m_pdata = evq[0].d;
                void'(evq.pop_front());
            end
        end
        chk("data_valid", data_valid, edv);
        chk("par_err", par_err, epe);
        chk("stp_err", stp_err, ese);
        chk("P_Data", P_Data, m_pdata);
        if (data_valid) begin
            dv_seen++;
            last_dv_cyc = cyc;
            dv_log.push_back(P_Data);
        end
        if (par_err) pe_seen++;
        if (stp_err) se_seen++;
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic drive_bit(input logic b, input int p);
        rx_in = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic stopb, output int s);
        int  p, nb;
        bit  pbad, sbad;
        ev_t e;
        p    = int'(prescale);
        nb   = 1 + 8 + (Par_en ? 1 : 0);
        s    = cyc;
        pbad = Par_en && (pbit != ((^d) ^ Par_type));
        sbad = !stopb;
        e.at = s + 1 + 2 + nb * p + p / 2 + 2;
        e.dv = !pbad && !sbad;
        e.pe = pbad;
        e.se = sbad;
        e.d  = d;
        evq.push_back(e);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (Par_en) drive_bit(pbit, p);
        drive_bit(stopb, p);
        rx_in = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (evq.size() > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t > 0) #1;
        chk("drain_timeout", evq.size(), 0);
    endtask

    int s0;
    int s_dummy;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        chk("reset_P_Data", P_Data, 8'h00);
        chk("reset_dv", data_valid, 1'b0);

        prescale = 6'd8; Par_en = 1'b1; Par_type = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, s0);
        drain();
        idle(4);
        chk("a5_data", P_Data, 8'hA5);
        chk("a5_latency", last_dv_cyc - s0, 89);
        chk("a5_dv_count", dv_seen, 1);

        prescale = 6'd16; Par_en = 1'b1; Par_type = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, s_dummy);
        drain();
        idle(4);
        chk("3c_data", P_Data, 8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, s_dummy);
        drain();
        idle(4);
        chk("3c_par_err_count", pe_seen, 1);
        chk("3c_dv_count", dv_seen, 2);
        chk("3c_data_kept", P_Data, 8'h3C);

        prescale = 6'd8; Par_en = 1'b0; Par_type = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, s_dummy);
        drain();
        idle(20);
        chk("81_stp_count", se_seen, 1);
        chk("81_data_kept", P_Data, 8'h3C);
        send_frame(8'h81, 1'b0, 1'b1, s_dummy);
        drain();
        idle(4);
        chk("81_data", P_Data, 8'h81);
        chk("81_dv_count", dv_seen, 3);

        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(16);
        chk("glitch_dv_count", dv_seen, 3);
        chk("glitch_err_count", pe_seen + se_seen, 2);
        send_frame(8'h5A, 1'b0, 1'b1, s_dummy);
        drain();
        idle(4);
        chk("5a_data", P_Data, 8'h5A);

        prescale = 6'd32; Par_en = 1'b1; Par_type = 1'b0;
        send_frame(8'h00, 1'b0, 1'b1, s_dummy);
        send_frame(8'hFF, 1'b0, 1'b1, s_dummy);
        send_frame(8'h55, 1'b0, 1'b1, s_dummy);
        drain();
        idle(8);
        chk("b2b_dv_count", dv_seen, 7);
        chk("b2b_byte0", dv_log[4], 8'h00);
        chk("b2b_byte1", dv_log[5], 8'hFF);
        chk("b2b_byte2", dv_log[6], 8'h55);

        prescale = 6'd8; Par_en = 1'b0;
        rx_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0, 8);
        drive_bit(1'b0, 4);
        rst = 1'b0;
        #1;
        chk("rst_P_Data", P_Data, 8'h00);
        chk("rst_flags", {data_valid, par_err, stp_err}, 3'b000);
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(6);
        send_frame(8'hC3, 1'b0, 1'b1, s_dummy);
        drain();
        idle(6);
        chk("c3_data", P_Data, 8'hC3);
        chk("c3_dv_count", dv_seen, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
